stream_packet_arbiter: RTL and testbench

//  Packet-level round-robin arbiter sharing one AXI-stream byte sink (the UART emitter) between N stream sources.

---
 rtl/stream_arb_pkg.sv | 14 +
 rtl/stream_packet_arbiter_rr_pick.sv | 30 +++
 rtl/stream_packet_arbiter.sv | 134 +++++++++++++
 tb/tb_stream_packet_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the packet-level stream arbiter.
// The FLUSH state is only reachable when STREAM_ARB_TIMEOUT_EN is defined.
package stream_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } arb_state_e;

    localparam logic [7:0] FILLER          = 8'h0A;
    localparam int         DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/stream_packet_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest set bit,
// then un-rotate so the result is an absolute source index.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [N-1:0] rot;

    always_comb begin
        rot   = '0;
        found = |req;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[(i + int'(ptr)) % N];
        end
        // Walk downwards so the lowest rotated position is the last (winning) write.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = IW'((i + int'(ptr)) % N);
            end
        end
    end

endmodule

// File: rtl/stream_packet_arbiter.sv
// Packet-level round-robin arbiter: N AXI-stream sources share one byte sink, grant held until tlast.
// Optional stalled-owner timeout with filler flush is enabled by defining STREAM_ARB_TIMEOUT_EN.
module stream_packet_arbiter
    import stream_arb_pkg::*;
#(
    parameter int N       = 2,
    parameter int W       = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N*W-1:0] i_tdata,
    input  logic [N-1:0]   i_tlast,
    input  logic [N-1:0]   i_tvalid,
    output logic [N-1:0]   o_tready,
    output logic [W-1:0]   o_tdata,
    output logic           o_tlast,
    output logic           o_tvalid,
    input  logic           i_tready,
    output logic [IW-1:0]  o_grant
);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] grant_next;
    logic          pick_found;
    logic [W-1:0]  src_data;
    logic          src_last;
    logic          src_valid;

`ifdef STREAM_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    logic [7:0] cnt_q, cnt_d;
`endif

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (i_tvalid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        src_data   = i_tdata[int'(grant_q)*W +: W];
        src_last   = i_tlast[grant_q];
        src_valid  = i_tvalid[grant_q];
        grant_next = (int'(grant_q) == N - 1) ? '0 : grant_q + IW'(1);
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        o_tdata  = '0;
        o_tlast  = 1'b0;
        o_tvalid = 1'b0;
        o_tready = '0;
`ifdef STREAM_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef STREAM_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                o_tdata           = src_data;
                o_tlast           = src_last;
                o_tvalid          = src_valid;
                o_tready[grant_q] = i_tready;
                if (src_valid && i_tready && src_last) begin
                    state_d = IDLE;
                    ptr_d   = grant_next;
                end
`ifdef STREAM_ARB_TIMEOUT_EN
                if (src_valid) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_CNT) begin
                        state_d = FLUSH;
                    end
                end
`endif
            end
`ifdef STREAM_ARB_TIMEOUT_EN
            // Close the abandoned packet with a filler byte; the source is not drained here.
            FLUSH: begin
                o_tdata  = W'(FILLER);
                o_tlast  = 1'b1;
                o_tvalid = 1'b1;
                if (i_tready) begin
                    state_d = IDLE;
                    ptr_d   = grant_next;
                    cnt_d   = '0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign o_grant = grant_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
`ifdef STREAM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
`ifdef STREAM_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Directed, table-driven bench for stream_packet_arbiter (N=3, W=8, TIMEOUT=4).
// The timeout rows run only when STREAM_ARB_TIMEOUT_EN is defined.
module tb_stream_packet_arbiter;

    typedef struct {
        logic [2:0] v;
        logic [2:0] l;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       rdy;
        logic       e_v;
        logic [7:0] e_d;
        logic       e_l;
        logic [2:0] e_r;
        logic [1:0] e_g;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  vin, lin;
    logic [7:0]  d0, d1, d2;
    logic        rdy;
    logic [2:0]  o_tready;
    logic [7:0]  o_tdata;
    logic        o_tlast, o_tvalid;
    logic [1:0]  o_grant;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];
    vec_t tvecs[$];

    always #5 clk = ~clk;

    stream_packet_arbiter #(
        .N       (3),
        .W       (8),
        .TIMEOUT (4)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_tdata  ({d2, d1, d0}),
        .i_tlast  (lin),
        .i_tvalid (vin),
        .o_tready (o_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .i_tready (rdy),
        .o_grant  (o_grant)
    );

    function automatic vec_t mk(input logic [2:0] v, input logic [2:0] l,
                                input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                input logic r, input logic ev, input logic [7:0] ed,
                                input logic el, input logic [2:0] er, input logic [1:0] eg);
        vec_t t;
        t.v = v; t.l = l; t.d0 = a; t.d1 = b; t.d2 = c; t.rdy = r;
        t.e_v = ev; t.e_d = ed; t.e_l = el; t.e_r = er; t.e_g = eg;
        return t;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, row, got, exp);
        end
    endtask

    task automatic run_vec(input string tag, input int row, input vec_t t);
        vin = t.v; lin = t.l; d0 = t.d0; d1 = t.d1; d2 = t.d2; rdy = t.rdy;
        @(negedge clk);
        chk({tag, "_tvalid"}, row, 32'(o_tvalid), 32'(t.e_v));
        chk({tag, "_tdata"},  row, 32'(o_tdata),  32'(t.e_d));
        chk({tag, "_tlast"},  row, 32'(o_tlast),  32'(t.e_l));
        chk({tag, "_tready"}, row, 32'(o_tready), 32'(t.e_r));
        chk({tag, "_grant"},  row, 32'(o_grant),  32'(t.e_g));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Round-robin, 2-beat packets from all three sources, sink always ready.
        vecs.push_back(mk(3'b111, 3'b000, 8'h10, 8'h20, 8'h30, 1, 0, 8'h00, 0, 3'b000, 2'd0));
        vecs.push_back(mk(3'b111, 3'b000, 8'h10, 8'h20, 8'h30, 1, 1, 8'h10, 0, 3'b001, 2'd0));
        vecs.push_back(mk(3'b111, 3'b001, 8'h11, 8'h20, 8'h30, 1, 1, 8'h11, 1, 3'b001, 2'd0));
        vecs.push_back(mk(3'b111, 3'b000, 8'h10, 8'h20, 8'h30, 1, 0, 8'h00, 0, 3'b000, 2'd0));
        vecs.push_back(mk(3'b111, 3'b000, 8'h10, 8'h20, 8'h30, 1, 1, 8'h20, 0, 3'b010, 2'd1));
        vecs.push_back(mk(3'b111, 3'b010, 8'h10, 8'h21, 8'h30, 1, 1, 8'h21, 1, 3'b010, 2'd1));
        vecs.push_back(mk(3'b111, 3'b000, 8'h10, 8'h20, 8'h30, 1, 0, 8'h00, 0, 3'b000, 2'd1));
        vecs.push_back(mk(3'b111, 3'b000, 8'h10, 8'h20, 8'h30, 1, 1, 8'h30, 0, 3'b100, 2'd2));
        vecs.push_back(mk(3'b111, 3'b100, 8'h10, 8'h20, 8'h31, 1, 1, 8'h31, 1, 3'b100, 2'd2));
        vecs.push_back(mk(3'b111, 3'b000, 8'h10, 8'h20, 8'h30, 1, 0, 8'h00, 0, 3'b000, 2'd2));
        vecs.push_back(mk(3'b111, 3'b000, 8'h10, 8'h20, 8'h30, 1, 1, 8'h10, 0, 3'b001, 2'd0));
        vecs.push_back(mk(3'b111, 3'b001, 8'h11, 8'h20, 8'h30, 1, 1, 8'h11, 1, 3'b001, 2'd0));
        // No interleave: source 1 waits through source 0's 4-beat packet (ptr wraps 1 -> 0).
        vecs.push_back(mk(3'b001, 3'b000, 8'h40, 8'h00, 8'h00, 1, 0, 8'h00, 0, 3'b000, 2'd0));
        vecs.push_back(mk(3'b011, 3'b010, 8'h40, 8'h50, 8'h00, 1, 1, 8'h40, 0, 3'b001, 2'd0));
        vecs.push_back(mk(3'b011, 3'b010, 8'h41, 8'h50, 8'h00, 1, 1, 8'h41, 0, 3'b001, 2'd0));
        vecs.push_back(mk(3'b011, 3'b010, 8'h42, 8'h50, 8'h00, 1, 1, 8'h42, 0, 3'b001, 2'd0));
        vecs.push_back(mk(3'b011, 3'b011, 8'h43, 8'h50, 8'h00, 1, 1, 8'h43, 1, 3'b001, 2'd0));
        vecs.push_back(mk(3'b010, 3'b010, 8'h00, 8'h50, 8'h00, 1, 0, 8'h00, 0, 3'b000, 2'd0));
        vecs.push_back(mk(3'b010, 3'b010, 8'h00, 8'h50, 8'h00, 1, 1, 8'h50, 1, 3'b010, 2'd1));
        // Sink stalls and a source valid gap inside source 2's packet.
        vecs.push_back(mk(3'b100, 3'b000, 8'h00, 8'h00, 8'h60, 1, 0, 8'h00, 0, 3'b000, 2'd1));
        vecs.push_back(mk(3'b100, 3'b000, 8'h00, 8'h00, 8'h60, 0, 1, 8'h60, 0, 3'b000, 2'd2));
        vecs.push_back(mk(3'b100, 3'b000, 8'h00, 8'h00, 8'h60, 1, 1, 8'h60, 0, 3'b100, 2'd2));
        vecs.push_back(mk(3'b000, 3'b000, 8'h00, 8'h00, 8'h61, 1, 0, 8'h61, 0, 3'b100, 2'd2));
        vecs.push_back(mk(3'b100, 3'b100, 8'h00, 8'h00, 8'h61, 0, 1, 8'h61, 1, 3'b000, 2'd2));
        vecs.push_back(mk(3'b100, 3'b100, 8'h00, 8'h00, 8'h61, 1, 1, 8'h61, 1, 3'b100, 2'd2));
        vecs.push_back(mk(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 3'b000, 2'd2));
        // Lone requester: three single-beat packets from source 2, one every other cycle.
        vecs.push_back(mk(3'b100, 3'b100, 8'h00, 8'h00, 8'h70, 1, 0, 8'h00, 0, 3'b000, 2'd2));
        vecs.push_back(mk(3'b100, 3'b100, 8'h00, 8'h00, 8'h70, 1, 1, 8'h70, 1, 3'b100, 2'd2));
        vecs.push_back(mk(3'b100, 3'b100, 8'h00, 8'h00, 8'h71, 1, 0, 8'h00, 0, 3'b000, 2'd2));
        vecs.push_back(mk(3'b100, 3'b100, 8'h00, 8'h00, 8'h71, 1, 1, 8'h71, 1, 3'b100, 2'd2));
        vecs.push_back(mk(3'b100, 3'b100, 8'h00, 8'h00, 8'h72, 1, 0, 8'h00, 0, 3'b000, 2'd2));
        vecs.push_back(mk(3'b100, 3'b100, 8'h00, 8'h00, 8'h72, 1, 1, 8'h72, 1, 3'b100, 2'd2));

        // Timeout: source 0 sends 'A' then idles for 4 cycles; filler closes the packet.
        tvecs.push_back(mk(3'b011, 3'b010, 8'h41, 8'h55, 8'h00, 1, 0, 8'h00, 0, 3'b000, 2'd2));
        tvecs.push_back(mk(3'b011, 3'b010, 8'h41, 8'h55, 8'h00, 1, 1, 8'h41, 0, 3'b001, 2'd0));
        for (int k = 0; k < 4; k++)
            tvecs.push_back(mk(3'b010, 3'b010, 8'h41, 8'h55, 8'h00, 1, 0, 8'h41, 0, 3'b001, 2'd0));
        tvecs.push_back(mk(3'b010, 3'b010, 8'h41, 8'h55, 8'h00, 1, 1, 8'h0A, 1, 3'b000, 2'd0));
        tvecs.push_back(mk(3'b010, 3'b010, 8'h41, 8'h55, 8'h00, 1, 0, 8'h00, 0, 3'b000, 2'd0));
        tvecs.push_back(mk(3'b010, 3'b010, 8'h41, 8'h55, 8'h00, 1, 1, 8'h55, 1, 3'b010, 2'd1));

        // Reset held with every source valid.
        rst = 1'b1; vin = 3'b111; lin = 3'b000; d0 = 8'h10; d1 = 8'h20; d2 = 8'h30; rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_tvalid", k, 32'(o_tvalid), 32'd0);
            chk("rst_tready", k, 32'(o_tready), 32'd0);
            chk("rst_tdata",  k, 32'(o_tdata),  32'd0);
            chk("rst_tlast",  k, 32'(o_tlast),  32'd0);
            chk("rst_grant",  k, 32'(o_grant),  32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec("tbl", i, vecs[i]);
`ifdef STREAM_ARB_TIMEOUT_EN
        for (int i = 0; i < tvecs.size(); i++) run_vec("tmo", i, tvecs[i]);
`endif

        // Reset in the middle of a packet abandons it; the arbiter re-arbitrates after release.
        vin = 3'b001; lin = 3'b000; d0 = 8'h80; d1 = 8'h00; d2 = 8'h00; rdy = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_busy_tvalid", 0, 32'(o_tvalid), 32'd1);
        chk("mid_busy_tdata",  0, 32'(o_tdata),  32'h80);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tvalid", 0, 32'(o_tvalid), 32'd0);
        chk("mid_rst_tready", 0, 32'(o_tready), 32'd0);
        chk("mid_rst_grant",  0, 32'(o_grant),  32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_regrant_tvalid", 0, 32'(o_tvalid), 32'd1);
        chk("mid_regrant_tdata",  0, 32'(o_tdata),  32'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
